// File: rtl/uart_rx_majority_sampler.sv
// UART RX oversampled bit decision.
// The RX line is synchronised, then a 3- or 5-tap majority vote is taken around
// the middle of each bit. Each completed vote produces a one-cycle Sample_Valid
// strobe together with the decided bit and a noise flag.
// Strobe semantics: Sample_Valid is a one-cycle pulse with no ready/backpressure.
// Sampled_Bit and Noise_Flag are valid in the same cycle as the pulse and hold
// their values until the next pulse.
module uart_rx_majority_sampler #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      RX_In,
  input  logic                      Data_Samp_En,
  input  logic [PRESCALE_WIDTH-1:0] Edge_Cnt,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      Samp_Mode,
  output logic                      Sampled_Bit,
  output logic                      Sample_Valid,
  output logic                      Noise_Flag,
  output logic                      Config_Err
);

  localparam int PW = PRESCALE_WIDTH;

  logic          rx_s;
  logic [PW-1:0] cfg_prescale_q;
  logic          cfg_mode_q;
  logic          cfg_err_q;
  logic [2:0]    ones_cnt_q;
  logic [2:0]    tap_cnt_q;
  logic          sampled_bit_q;
  logic          sample_valid_q;
  logic          noise_flag_q;

  // Synchroniser: with zero stages the line is used as-is.
  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign rx_s = RX_In;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      // Shift RX_In through the chain; the chain resets to the idle level.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync_q <= '1;
        end else begin
          sync_q[0] <= RX_In;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end
      assign rx_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Configuration follows the inputs while idle and freezes for the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_prescale_q <= '0;
      cfg_mode_q     <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else if (!Data_Samp_En) begin
      cfg_prescale_q <= Prescale;
      cfg_mode_q     <= Samp_Mode;
      cfg_err_q      <= (Prescale < PW'(4)) || (Samp_Mode && (Prescale < PW'(8)));
    end
  end

  // Tap window geometry derived from the frozen configuration.
  logic [PW-1:0] half_k;
  logic [PW-1:0] mid;
  logic [PW-1:0] win_lo;
  logic [PW-1:0] win_hi;
  logic [PW-1:0] dec_edge;
  logic [2:0]    k3;
  logic [2:0]    n_taps;
  logic          in_win;
  logic          dec_fire;

  assign half_k   = cfg_mode_q ? PW'(2) : PW'(1);
  assign k3       = cfg_mode_q ? 3'd2 : 3'd1;
  assign n_taps   = cfg_mode_q ? 3'd5 : 3'd3;
  assign mid      = (cfg_prescale_q >> 1) - PW'(1);
  assign win_lo   = mid - half_k;
  assign win_hi   = mid + half_k;
  assign dec_edge = win_hi + PW'(1);
  assign in_win   = (Edge_Cnt >= win_lo) && (Edge_Cnt <= win_hi);
  // A vote is only decided if every tap of the window was collected.
  assign dec_fire = Data_Samp_En && !cfg_err_q && (Edge_Cnt == dec_edge) &&
                    (tap_cnt_q == n_taps);

  // Tap accumulator: restarts on each bit and whenever sampling is disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones_cnt_q <= '0;
      tap_cnt_q  <= '0;
    end else if (!Data_Samp_En || (Edge_Cnt == '0)) begin
      ones_cnt_q <= '0;
      tap_cnt_q  <= '0;
    end else if (in_win && !cfg_err_q) begin
      ones_cnt_q <= ones_cnt_q + {2'b00, rx_s};
      tap_cnt_q  <= tap_cnt_q + 3'd1;
    end
  end

  // Registered decision outputs; bit and noise hold between votes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sampled_bit_q  <= 1'b1;
      sample_valid_q <= 1'b0;
      noise_flag_q   <= 1'b0;
    end else begin
      sample_valid_q <= dec_fire;
      if (dec_fire) begin
        sampled_bit_q <= (ones_cnt_q > k3);
        noise_flag_q  <= (ones_cnt_q != 3'd0) && (ones_cnt_q != n_taps);
      end
    end
  end

  assign Sampled_Bit  = sampled_bit_q;
  assign Sample_Valid = sample_valid_q;
  assign Noise_Flag   = noise_flag_q;
  assign Config_Err   = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_majority_sampler.sv
// Bench for uart_rx_majority_sampler: bit-level driver with an expected-result
// queue filled from a majority-vote model of each driven bit.
module tb_uart_rx_majority_sampler;

  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic          en;
  logic [PW-1:0] edge_cnt;
  logic [PW-1:0] prescale;
  logic          samp_mode;
  logic          sampled_bit;
  logic          sample_valid;
  logic          noise_flag;
  logic          config_err;

  uart_rx_majority_sampler #(.PRESCALE_WIDTH(PW), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .RX_In        (rx_in),
    .Data_Samp_En (en),
    .Edge_Cnt     (edge_cnt),
    .Prescale     (prescale),
    .Samp_Mode    (samp_mode),
    .Sampled_Bit  (sampled_bit),
    .Sample_Valid (sample_valid),
    .Noise_Flag   (noise_flag),
    .Config_Err   (config_err)
  );

  // Clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];   // {bit, noise}

  typedef struct packed {
    logic          en;
    logic [PW-1:0] ec;
    logic [PW-1:0] ps;
    logic          mode;
  } ctl_t;

  // Control lags the RX line by two cycles to match the synchroniser delay.
  ctl_t d0, d1;
  int   cur_ps;
  bit   cur_mode;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ctl_t mk(input logic e, input int ec, input int ps, input logic m);
    ctl_t c;
    c.en = e; c.ec = PW'(ec); c.ps = PW'(ps); c.mode = m;
    return c;
  endfunction

  task automatic apply(input ctl_t c);
    en = c.en; edge_cnt = c.ec; prescale = c.ps; samp_mode = c.mode;
  endtask

  task automatic step(input ctl_t c, input logic rx);
    @(posedge clk); #1;
    rx_in = rx;
    apply(d1);
    d1 = d0;
    d0 = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(mk(1'b0, 0, cur_ps, cur_mode), 1'b1);
  endtask

  // line[e] is the value the sampler should see at edge e of this bit.
  task automatic drive_bit(input int ps, input bit mode, input logic [31:0] line,
                           input int ps_drv, input int first_e, input int last_e,
                           input int lead);
    int k, mid, lo, hi, ones;
    bit ok;
    cur_ps = ps; cur_mode = mode;
    for (int i = 0; i < lead; i++) step(mk(1'b0, 0, ps, mode), 1'b1);
    k   = mode ? 2 : 1;
    mid = ps / 2 - 1;
    lo  = mid - k;
    hi  = mid + k;
    ok  = (ps >= 4) && !(mode && ps < 8) && (first_e <= lo) && (last_e >= hi + 1) &&
          (hi + 1 < ps);
    if (ok) begin
      ones = 0;
      for (int e = lo; e <= hi; e++) ones += int'(line[e]);
      exp_q.push_back({ones > k, (ones != 0) && (ones != 2 * k + 1)});
    end
    for (int e = 0; e < ps; e++) begin
      logic on;
      on = (e >= first_e) && (e <= last_e);
      step(mk(on, e, on ? ps_drv : ps, mode), line[e]);
    end
  endtask

  // Scoreboard: every pulse must match the oldest expected vote.
  always @(negedge clk) begin
    if (rst === 1'b1 && sample_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexp_pulse", 1, 0);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("bit", sampled_bit, e[1]);
        check("noise", noise_flag, e[0]);
      end
    end
  end

  initial begin
    int ps, r;
    bit m;
    rst = 1'b0; rx_in = 1'b1; en = 1'b0; edge_cnt = '0; prescale = 6'd8; samp_mode = 1'b0;
    cur_ps = 8; cur_mode = 1'b0;
    d0 = mk(1'b0, 0, 8, 1'b0);
    d1 = d0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bit", sampled_bit, 1);
    check("rst_valid", sample_valid, 0);
    check("rst_noise", noise_flag, 0);
    check("rst_cfgerr", config_err, 0);
    rst = 1'b1;
    idle(3);

    // 3-tap, steady 0 on edges 2..4
    drive_bit(8, 1'b0, 32'hFFFF_FFE3, 8, 0, 7, 2);
    // 5-tap, taps 0,1,0,1,0 on edges 1..5
    drive_bit(8, 1'b1, 32'hFFFF_FFD5, 8, 0, 7, 2);
    // 5-tap prescale 16, taps 1,1,0,1,0 on edges 5..9, then a clean 1 back-to-back
    drive_bit(16, 1'b1, 32'h0000_0160, 16, 0, 15, 2);
    drive_bit(16, 1'b1, 32'hFFFF_FFFF, 16, 0, 15, 0);
    idle(4);

    // Prescale 6 cannot hold 5 taps; 3 taps fit
    drive_bit(6, 1'b1, 32'h0, 6, 0, 5, 2);
    idle(3);
    check("cfgerr_6_5tap", config_err, 1);
    drive_bit(6, 1'b0, 32'h0, 6, 0, 5, 2);
    idle(3);
    check("cfgerr_6_3tap", config_err, 0);

    // Enable dropped after two taps, then a late-entered window
    drive_bit(8, 1'b0, 32'h0, 8, 0, 3, 2);
    drive_bit(8, 1'b0, 32'h0, 8, 3, 7, 2);
    idle(3);

    // Reset in the middle of a window
    cur_ps = 8; cur_mode = 1'b0;
    idle(2);
    for (int e = 0; e < 4; e++) step(mk(1'b1, e, 8, 1'b0), 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    d0 = mk(1'b0, 0, 8, 1'b0);
    d1 = d0;
    apply(d0);
    rx_in = 1'b1;
    @(posedge clk); #1;
    check("midrst_bit", sampled_bit, 1);
    check("midrst_valid", sample_valid, 0);
    check("midrst_noise", noise_flag, 0);
    rst = 1'b1;
    idle(3);
    drive_bit(8, 1'b0, 32'h0, 8, 0, 7, 2);

    // Prescale changed while enabled is ignored
    drive_bit(8, 1'b0, 32'hFFFF_FFE3, 16, 0, 7, 2);
    drive_bit(8, 1'b1, 32'h0000_001C, 4, 0, 7, 2);

    // Random bits
    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 3);
      ps = (r == 0) ? 8 : (r == 1) ? 10 : (r == 2) ? 12 : 16;
      m = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0 && i > 0) begin
        drive_bit(cur_ps, cur_mode, $urandom, cur_ps, 0, cur_ps - 1, 0);
      end else begin
        drive_bit(ps, m, $urandom, ps, 0, ps - 1, 1);
      end
    end

    idle(6);
    check("missing_pulse", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
